// File: rtl/pwm_tick_if.sv
// ---------------------------------------------------------------------------
// pwm_tick_if
// Duty-cycle request channel for pwm_tick. The requester drives a duty
// value with a valid flag and holds both until it samples ready high; the
// PWM block raises ready whenever its shadow slot is free.
//
//   duty        requested high-time in ticks        (master -> slave)
//   duty_valid  request valid                       (master -> slave)
//   duty_ready  shadow slot free, request accepted  (slave  -> master)
//
// LEN defaults to the width pwm_tick derives for its default PERIOD of 250.
// ---------------------------------------------------------------------------
interface pwm_tick_if #(
   parameter int LEN = 8
);

   logic [LEN-1:0] duty;
   logic           duty_valid;
   logic           duty_ready;

   modport master (
      output duty,
      output duty_valid,
      input  duty_ready
   );

   modport slave (
      input  duty,
      input  duty_valid,
      output duty_ready
   );

endinterface

// File: rtl/pwm_tick.sv
// ---------------------------------------------------------------------------
// pwm_tick
// PWM generator fed by the clock divider's output. Rising edges of tick_in
// are detected in the clk domain; each one advances a period counter, and
// pwm is high while the counter is below the active duty. New duty values
// arrive over a valid/ready channel into a shadow register and are only
// copied into the active duty at a period boundary, so a pulse already in
// progress is never shortened or stretched.
//
// Ports:
//   clk           system clock
//   rst           asynchronous reset, active low
//   tick_in       divided clock from the clock divider, synchronous to clk
//   en            run enable; dropping it returns to IDLE on the next edge
//   duty_if       duty request channel (duty / duty_valid / duty_ready)
//   pwm           registered PWM output
//   period_start  one-clk pulse on the edge that begins each period
// ---------------------------------------------------------------------------
module pwm_tick #(
   parameter int PERIOD = 250,
   parameter int LEN    = $clog2(PERIOD + 1)
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      tick_in,
   input  logic      en,
   pwm_tick_if.slave duty_if,
   output logic      pwm,
   output logic      period_start
);

   localparam logic [LEN-1:0] PERIOD_L = LEN'(PERIOD);
   localparam logic [LEN-1:0] LAST_CNT = LEN'(PERIOD - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t         state;
   state_t         state_next;
   logic           tick_d;
   logic           tick;
   logic [LEN-1:0] cnt;
   logic [LEN-1:0] cnt_next;
   logic [LEN-1:0] duty_act;
   logic [LEN-1:0] duty_act_next;
   logic [LEN-1:0] duty_shadow;
   logic [LEN-1:0] duty_clamped;
   logic           pending;
   logic           xfer;
   logic           boundary;
   logic           pwm_next;
   logic           period_start_next;

   // A level held high on tick_in must count once, so only the low-to-high
   // transition produces a tick.
   assign tick = tick_in & ~tick_d;

   // The shadow holds at most one outstanding request; while it is full the
   // requester is stalled and anything it presents is simply not taken.
   assign duty_if.duty_ready = ~pending;
   assign xfer               = duty_if.duty_valid & ~pending;

   // Requests above the period would mean "always high", which PERIOD already
   // expresses, so they saturate instead of wrapping in the compare.
   assign duty_clamped = (duty_if.duty > PERIOD_L) ? PERIOD_L : duty_if.duty;

   // Edge-detect delay register for the incoming divided clock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_d <= 1'b0;
      end else begin
         tick_d <= tick_in;
      end
   end

   // State register of the IDLE/RUN controller.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: start on the first enabled tick, stop as soon as the
   // enable goes away regardless of any tick arriving on the same edge.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (en && tick) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (!en) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath next values. A "boundary" is any edge that begins a period
   // (leaving IDLE or wrapping in RUN); only there does the shadow duty move
   // into the active duty. pwm is computed from the post-edge counter and
   // duty so the output lines up with the counter it describes.
   always_comb begin
      cnt_next          = cnt;
      duty_act_next     = duty_act;
      pwm_next          = pwm;
      period_start_next = 1'b0;
      boundary          = 1'b0;
      case (state)
         IDLE: begin
            cnt_next = '0;
            pwm_next = 1'b0;
            if (en && tick) begin
               boundary          = 1'b1;
               duty_act_next     = duty_shadow;
               period_start_next = 1'b1;
               pwm_next          = (duty_shadow != '0);
            end
         end
         RUN: begin
            if (!en) begin
               cnt_next = '0;
               pwm_next = 1'b0;
            end else if (tick) begin
               if (cnt == LAST_CNT) begin
                  cnt_next          = '0;
                  boundary          = 1'b1;
                  duty_act_next     = duty_shadow;
                  period_start_next = 1'b1;
               end else begin
                  cnt_next = cnt + LEN'(1);
               end
               pwm_next = (cnt_next < duty_act_next);
            end
         end
         default: begin
            cnt_next = '0;
            pwm_next = 1'b0;
         end
      endcase
   end

   // Counter, active duty and the registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt          <= '0;
         duty_act     <= '0;
         pwm          <= 1'b0;
         period_start <= 1'b0;
      end else begin
         cnt          <= cnt_next;
         duty_act     <= duty_act_next;
         pwm          <= pwm_next;
         period_start <= period_start_next;
      end
   end

   // Shadow slot. A boundary empties it, but a request accepted on that same
   // edge refills it: the active duty took the old shadow value, and the new
   // one waits for the following boundary.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         duty_shadow <= '0;
         pending     <= 1'b0;
      end else begin
         if (boundary) begin
            pending <= 1'b0;
         end
         if (xfer) begin
            duty_shadow <= duty_clamped;
            pending     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pwm_tick.sv
// ---------------------------------------------------------------------------
// tb_pwm_tick
// Bench for pwm_tick with PERIOD=4. tick_in is a 20-clk square wave (10 high,
// 10 low) generated tick by tick from the test tasks. For every tick the
// expected pwm / period_start behaviour is pushed to a queue, the tick is
// driven, and the observed response is popped against it.
// ---------------------------------------------------------------------------
module tb_pwm_tick;

   localparam int PERIOD = 4;
   localparam int LEN    = 3;

   logic clk;
   logic rst;
   logic tick_in;
   logic en;
   logic pwm;
   logic period_start;

   pwm_tick_if #(.LEN(LEN)) duty_if ();

   pwm_tick #(
      .PERIOD (PERIOD),
      .LEN    (LEN)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .tick_in      (tick_in),
      .en           (en),
      .duty_if      (duty_if),
      .pwm          (pwm),
      .period_start (period_start)
   );

   int checks_total;
   int checks_passed;

   // Expected per-tick response: {pwm, period_start, period_start a cycle
   // later, pwm steady for the rest of the tick period}.
   logic [3:0] exp_q[$];

   // 10-unit system clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so a stuck run still ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // One rising edge of tick_in, held hi_len negedges high then 10 low.
   // Optionally presents a duty request on the very edge the tick is seen.
   task automatic drive_tick(input logic hs, input logic [LEN-1:0] hs_duty,
                             input int hi_len, output logic [3:0] obs);
      logic p;
      logic s;
      logic sn;
      logic stable;
      @(negedge clk);
      tick_in = 1'b1;
      if (hs) begin
         duty_if.duty       = hs_duty;
         duty_if.duty_valid = 1'b1;
      end
      @(negedge clk);
      duty_if.duty_valid = 1'b0;
      p = pwm;
      s = period_start;
      @(negedge clk);
      sn     = period_start;
      stable = (pwm === p);
      for (int i = 2; i < hi_len; i++) begin
         @(negedge clk);
         if (pwm !== p) stable = 1'b0;
      end
      tick_in = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (pwm !== p) stable = 1'b0;
      end
      obs = {p, s, sn, stable};
   endtask

   // Single-cycle duty request, used only when duty_ready is known high.
   task automatic send_duty(input logic [LEN-1:0] d);
      @(negedge clk);
      duty_if.duty       = d;
      duty_if.duty_valid = 1'b1;
      @(negedge clk);
      duty_if.duty_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks_total++;
      if (pwm !== 1'b0) $display("[TB] FAIL reset_pwm observed=%b required=0", pwm);
      else checks_passed++;
      checks_total++;
      if (period_start !== 1'b0) $display("[TB] FAIL reset_ps observed=%b required=0", period_start);
      else checks_passed++;
      checks_total++;
      if (duty_if.duty_ready !== 1'b1) $display("[TB] FAIL reset_ready observed=%b required=1", duty_if.duty_ready);
      else checks_passed++;
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [3:0] obs;
      logic [3:0] exp;
      send_duty(3'd1);
      checks_total++;
      if (duty_if.duty_ready !== 1'b0) $display("[TB] FAIL basic_ready_low observed=%b required=0", duty_if.duty_ready);
      else checks_passed++;
      en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         exp_q.push_back({(k % 4) < 1, (k % 4) == 0, 1'b0, 1'b1});
         drive_tick(1'b0, '0, 10, obs);
         exp = exp_q.pop_front();
         checks_total++;
         if (obs !== exp) $display("[TB] FAIL basic_tick%0d observed=%b required=%b", k, obs, exp);
         else checks_passed++;
      end
      checks_total++;
      if (duty_if.duty_ready !== 1'b1) $display("[TB] FAIL basic_ready_high observed=%b required=1", duty_if.duty_ready);
      else checks_passed++;
   endtask

   task automatic test_update();
      logic [3:0] obs;
      logic [3:0] exp;
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back({k == 0, k == 0, 1'b0, 1'b1});
         drive_tick(1'b0, '0, 10, obs);
         exp = exp_q.pop_front();
         checks_total++;
         if (obs !== exp) $display("[TB] FAIL update_pre%0d observed=%b required=%b", k, obs, exp);
         else checks_passed++;
      end
      send_duty(3'd3);
      checks_total++;
      if (duty_if.duty_ready !== 1'b0) $display("[TB] FAIL update_ready_low observed=%b required=0", duty_if.duty_ready);
      else checks_passed++;
      @(negedge clk);
      duty_if.duty       = 3'd2;
      duty_if.duty_valid = 1'b1;
      repeat (3) @(negedge clk);
      duty_if.duty_valid = 1'b0;
      exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1});
      drive_tick(1'b0, '0, 10, obs);
      exp = exp_q.pop_front();
      checks_total++;
      if (obs !== exp) $display("[TB] FAIL update_last_old observed=%b required=%b", obs, exp);
      else checks_passed++;
      checks_total++;
      if (duty_if.duty_ready !== 1'b0) $display("[TB] FAIL update_ready_held observed=%b required=0", duty_if.duty_ready);
      else checks_passed++;
      for (int k = 0; k < 8; k++) begin
         exp_q.push_back({(k % 4) < 3, (k % 4) == 0, 1'b0, 1'b1});
         drive_tick(1'b0, '0, 10, obs);
         exp = exp_q.pop_front();
         checks_total++;
         if (obs !== exp) $display("[TB] FAIL update_new%0d observed=%b required=%b", k, obs, exp);
         else checks_passed++;
      end
      checks_total++;
      if (duty_if.duty_ready !== 1'b1) $display("[TB] FAIL update_ready_free observed=%b required=1", duty_if.duty_ready);
      else checks_passed++;
   endtask

   task automatic test_boundaries();
      logic [3:0] obs;
      logic [3:0] exp;
      send_duty(3'd0);
      checks_total++;
      if (duty_if.duty_ready !== 1'b0) $display("[TB] FAIL zero_ready_low observed=%b required=0", duty_if.duty_ready);
      else checks_passed++;
      for (int k = 0; k < 12; k++) begin
         exp_q.push_back({1'b0, (k % 4) == 0, 1'b0, 1'b1});
         drive_tick(1'b0, '0, 10, obs);
         exp = exp_q.pop_front();
         checks_total++;
         if (obs !== exp) $display("[TB] FAIL zero_tick%0d observed=%b required=%b", k, obs, exp);
         else checks_passed++;
      end
      send_duty(3'd7);
      for (int k = 0; k < 12; k++) begin
         exp_q.push_back({1'b1, (k % 4) == 0, 1'b0, 1'b1});
         drive_tick(1'b0, '0, 10, obs);
         exp = exp_q.pop_front();
         checks_total++;
         if (obs !== exp) $display("[TB] FAIL full_tick%0d observed=%b required=%b", k, obs, exp);
         else checks_passed++;
      end
   endtask

   task automatic test_hold_and_disable();
      logic [3:0] obs;
      logic [3:0] exp;
      send_duty(3'd2);
      exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b1});
      drive_tick(1'b0, '0, 10, obs);
      exp = exp_q.pop_front();
      checks_total++;
      if (obs !== exp) $display("[TB] FAIL hold_wrap observed=%b required=%b", obs, exp);
      else checks_passed++;
      exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1});
      drive_tick(1'b0, '0, 100, obs);
      exp = exp_q.pop_front();
      checks_total++;
      if (obs !== exp) $display("[TB] FAIL hold_long observed=%b required=%b", obs, exp);
      else checks_passed++;
      @(negedge clk);
      checks_total++;
      if (pwm !== 1'b1) $display("[TB] FAIL disable_pre observed=%b required=1", pwm);
      else checks_passed++;
      en = 1'b0;
      @(negedge clk);
      checks_total++;
      if (pwm !== 1'b0) $display("[TB] FAIL disable_pwm observed=%b required=0", pwm);
      else checks_passed++;
      exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1});
      drive_tick(1'b0, '0, 10, obs);
      exp = exp_q.pop_front();
      checks_total++;
      if (obs !== exp) $display("[TB] FAIL idle_tick observed=%b required=%b", obs, exp);
      else checks_passed++;
      en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back({k < 2, k == 0, 1'b0, 1'b1});
         drive_tick(1'b0, '0, 10, obs);
         exp = exp_q.pop_front();
         checks_total++;
         if (obs !== exp) $display("[TB] FAIL restart_tick%0d observed=%b required=%b", k, obs, exp);
         else checks_passed++;
      end
   endtask

   task automatic test_wrap_handshake();
      logic [3:0] obs;
      logic [3:0] exp;
      send_duty(3'd1);
      for (int k = 0; k < 12; k++) begin
         if (k < 8) exp_q.push_back({(k % 4) < 1, (k % 4) == 0, 1'b0, 1'b1});
         else       exp_q.push_back({(k % 4) < 2, (k % 4) == 0, 1'b0, 1'b1});
         drive_tick(k == 4, 3'd2, 10, obs);
         exp = exp_q.pop_front();
         checks_total++;
         if (obs !== exp) $display("[TB] FAIL wraphs_tick%0d observed=%b required=%b", k, obs, exp);
         else checks_passed++;
         if (k == 4 || k == 8) begin
            checks_total++;
            if (duty_if.duty_ready !== (k == 8))
               $display("[TB] FAIL wraphs_ready%0d observed=%b required=%b", k, duty_if.duty_ready, k == 8);
            else checks_passed++;
         end
      end
   endtask

   task automatic test_async_reset();
      logic [3:0] obs;
      logic [3:0] exp;
      exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b1});
      drive_tick(1'b0, '0, 10, obs);
      exp = exp_q.pop_front();
      checks_total++;
      if (obs !== exp) $display("[TB] FAIL arst_wrap observed=%b required=%b", obs, exp);
      else checks_passed++;
      send_duty(3'd3);
      @(negedge clk);
      checks_total++;
      if ({pwm, duty_if.duty_ready} !== 2'b10) $display("[TB] FAIL arst_pre observed=%b required=10", {pwm, duty_if.duty_ready});
      else checks_passed++;
      #2;
      rst = 1'b0;
      #1;
      checks_total++;
      if (pwm !== 1'b0) $display("[TB] FAIL arst_pwm observed=%b required=0", pwm);
      else checks_passed++;
      checks_total++;
      if (period_start !== 1'b0) $display("[TB] FAIL arst_ps observed=%b required=0", period_start);
      else checks_passed++;
      checks_total++;
      if (duty_if.duty_ready !== 1'b1) $display("[TB] FAIL arst_ready observed=%b required=1", duty_if.duty_ready);
      else checks_passed++;
      en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // Scenario sequence; each task leaves the DUT in a state the next relies on.
   initial begin
      checks_total       = 0;
      checks_passed      = 0;
      tick_in            = 1'b0;
      en                 = 1'b0;
      duty_if.duty       = '0;
      duty_if.duty_valid = 1'b0;
      rst                = 1'b0;
      $display("[TB] starting pwm_tick bench");
      test_reset();
      test_basic();
      test_update();
      test_boundaries();
      test_hold_and_disable();
      test_wrap_handshake();
      test_async_reset();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
